rx_intf_m_axis_mc: RTL and testbench

- Multi-channel successor to the single-stream rx DMA AXI-Stream master.
- Accepts NUM_CH independent sample streams from the rx accumulators, each into its own FWFT FIFO.
- Per-channel start requests are queued; a round-robin scheduler emits one burst per request on a shared M_AXIS port.
- TDEST carries the channel id; TLAST marks the burst end, so the DMA can demultiplex.

---
 rtl/rx_intf_m_axis_pkg.sv | 48 ++++
 rtl/rx_intf_ch_fifo.sv | 66 ++++++
 rtl/rx_intf_m_axis_mc.sv | 212 +++++++++++++++++++++
 tb/tb_rx_intf_m_axis_mc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_intf_m_axis_pkg.sv
// ---------------------------------------------------------------------------
// rx_intf_m_axis_pkg
// Shared definitions for the multi-channel rx AXI-Stream master:
//   - scheduler state encodings (2-bit, legacy-compatible constants)
//   - clog2 helper usable in parameter expressions
//   - round-robin channel picker
// ---------------------------------------------------------------------------
package rx_intf_m_axis_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Upper bound on channel count; the channel id is carried in 2 bits.
    localparam int MAX_CH = 4;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Lowest pending index at or after last+1 (mod num_ch). Walking k downward
    // lets the nearest successor overwrite farther ones; k == num_ch revisits
    // 'last' itself, so it only wins when nobody else is pending.
    function automatic logic [1:0] rr_next(input logic [MAX_CH-1:0] pend,
                                           input logic [1:0]        last,
                                           input int                num_ch);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= num_ch) begin
                idx = 2'((int'(last) + k) % num_ch);
                if (pend[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rx_intf_ch_fifo.sv
// ---------------------------------------------------------------------------
// rx_intf_ch_fifo
// Single-clock first-word-fall-through FIFO for one rx channel. rd_data_o
// shows the head word whenever empty_o is low; rd_en_i pops it.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (empties FIFO)
//   wr_en_i, wr_data_i    push side; pushes while full are dropped unless a
//                         pop happens in the same cycle
//   full_n_o              not-full flag
//   rd_en_i, rd_data_o    pop side (zero-latency head word)
//   empty_o, count_o      occupancy status
// ---------------------------------------------------------------------------
module rx_intf_ch_fifo
    import rx_intf_m_axis_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4096,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_n_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o   = wptr_q - rptr_q;
    assign empty_o   = (wptr_q == rptr_q);
    assign full      = (count_o == (AW+1)'(DEPTH));
    assign full_n_o  = ~full;
    assign rd_ok     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok     = wr_en_i && (!full || rd_ok);
    assign rd_data_o = mem_q[rptr_q[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which words are
    // valid, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/rx_intf_m_axis_mc.sv
// ---------------------------------------------------------------------------
// rx_intf_m_axis_mc
// Multi-channel rx DMA AXI-Stream master. Each channel buffers accumulator
// samples in its own FWFT FIFO; rising edges of start_1trans queue one burst
// request per channel, and a round-robin scheduler emits N+1 beats per grant
// on the shared M_AXIS port with TDEST = channel id and TLAST on the last beat.
// Ports:
//   M_AXIS_ACLK, M_AXIS_ARESETN   clock, async active-low reset
//   endless_mode                  burst never ends, only channel 0 served
//   START_COUNT_CFG               idle cycles between grant and first beat
//   M_AXIS_NUM_DMA_SYMBOL         per-channel N (burst = N+1 beats)
//   start_1trans                  per-channel request level (rising edge)
//   DATA_FROM_ACC, ACC_DATA_READY per-channel FIFO write port
//   FULLN_TO_ACC, data_count      per-channel FIFO status
//   pend_req                      pending-request flags
//   M_AXIS_*                      AXI-Stream master
// Optional: define RX_INTF_M_AXIS_UNDERRUN_CNT_EN to add underrun_cnt, one
// saturating 16-bit counter per channel of stalled-by-empty-FIFO cycles.
// ---------------------------------------------------------------------------
module rx_intf_m_axis_mc
    import rx_intf_m_axis_pkg::*;
#(
    parameter  int NUM_CH                 = 2,
    parameter  int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter  int FIFO_DEPTH             = 4096,
    parameter  int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter  int WAIT_COUNT_BITS        = 5,
    parameter  int TDEST_WIDTH            = 2,
    localparam int W                      = C_M_AXIS_TDATA_WIDTH,
    localparam int NB                     = MAX_BIT_NUM_DMA_SYMBOL,
    localparam int CNT_W                  = clog2(FIFO_DEPTH) + 1
) (
    input  logic                       M_AXIS_ACLK,
    input  logic                       M_AXIS_ARESETN,
    input  logic                       endless_mode,
    input  logic [WAIT_COUNT_BITS-1:0] START_COUNT_CFG,
    input  logic [NUM_CH*NB-1:0]       M_AXIS_NUM_DMA_SYMBOL,
    input  logic [NUM_CH-1:0]          start_1trans,
    input  logic [NUM_CH*W-1:0]        DATA_FROM_ACC,
    input  logic [NUM_CH-1:0]          ACC_DATA_READY,
    output logic [NUM_CH-1:0]          FULLN_TO_ACC,
    output logic [NUM_CH*CNT_W-1:0]    data_count,
    output logic [NUM_CH-1:0]          pend_req,
`ifdef RX_INTF_M_AXIS_UNDERRUN_CNT_EN
    output logic [NUM_CH*16-1:0]       underrun_cnt,
`endif
    output logic                       M_AXIS_TVALID,
    output logic [W-1:0]               M_AXIS_TDATA,
    output logic [W/8-1:0]             M_AXIS_TSTRB,
    output logic                       M_AXIS_TLAST,
    output logic [TDEST_WIDTH-1:0]     M_AXIS_TDEST,
    input  logic                       M_AXIS_TREADY
);

    logic [NUM_CH-1:0]          start_q, req_edge, pend_q, pend_d, grant, eligible;
    logic [NUM_CH-1:0]          fifo_empty, fifo_rd;
    logic [W-1:0]               fifo_dout [NUM_CH];
    logic [1:0]                 state_q, state_d, ch_q, ch_d, last_q, last_d, pick;
    logic [NB-1:0]              n_q, n_d, pick_n;
    logic [NB:0]                ptr_q, ptr_d;
    logic [WAIT_COUNT_BITS-1:0] cfg_q, cfg_d, wcnt_q, wcnt_d;
    logic                       endless_q, endless_d;
    logic                       sel_empty, in_burst, tvalid, tlast, beat;
    logic [W-1:0]               sel_data;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rx_intf_ch_fifo #(
            .WIDTH (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (M_AXIS_ACLK),
            .rst_n     (M_AXIS_ARESETN),
            .wr_en_i   (ACC_DATA_READY[g]),
            .wr_data_i (DATA_FROM_ACC[g*W +: W]),
            .full_n_o  (FULLN_TO_ACC[g]),
            .rd_en_i   (fifo_rd[g]),
            .rd_data_o (fifo_dout[g]),
            .empty_o   (fifo_empty[g]),
            .count_o   (data_count[g*CNT_W +: CNT_W])
        );
    end

    // Request capture, channel selection and the shared datapath mux.
    always_comb begin
        req_edge = start_1trans & ~start_q;
        eligible = pend_q;
        for (int i = 1; i < NUM_CH; i++) begin
            if (endless_mode) eligible[i] = 1'b0;
        end
        pick      = rr_next(MAX_CH'(eligible), last_q, NUM_CH);
        pick_n    = '0;
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == 2'(i)) pick_n = M_AXIS_NUM_DMA_SYMBOL[i*NB +: NB];
            if (ch_q == 2'(i)) begin
                sel_empty = fifo_empty[i];
                sel_data  = fifo_dout[i];
            end
        end
        in_burst = endless_q || (ptr_q <= {1'b0, n_q});
        tvalid   = (state_q == ST_SEND) && !sel_empty && in_burst;
        beat     = tvalid && M_AXIS_TREADY;
        // Qualified by TVALID (not the handshake) so TLAST holds during a stall.
        tlast    = tvalid && (ptr_q == {1'b0, n_q}) && !endless_q;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i]   = (state_q == ST_IDLE) && (|eligible) && (pick == 2'(i));
            fifo_rd[i] = beat && (ch_q == 2'(i));
        end
        // An edge on the grant cycle wins over the clear and re-arms the flag.
        pend_d = (pend_q & ~grant) | req_edge;
    end

    // Burst scheduler.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        ch_d      = ch_q;
        n_d       = n_q;
        cfg_d     = cfg_q;
        wcnt_d    = wcnt_q;
        ptr_d     = ptr_q;
        endless_d = endless_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    ch_d      = pick;
                    n_d       = pick_n;
                    cfg_d     = START_COUNT_CFG;
                    endless_d = endless_mode;
                    wcnt_d    = '0;
                    ptr_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == cfg_q) state_d = ST_SEND;
                else                 wcnt_d  = wcnt_q + 1'b1;
            end
            ST_SEND: begin
                if (beat) begin
                    ptr_d = ptr_q + 1'b1;
                    if (tlast) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = ch_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            start_q   <= '0;
            pend_q    <= '0;
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            last_q    <= '0;
            n_q       <= '0;
            cfg_q     <= '0;
            wcnt_q    <= '0;
            ptr_q     <= '0;
            endless_q <= 1'b0;
        end else begin
            start_q   <= start_1trans;
            pend_q    <= pend_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            n_q       <= n_d;
            cfg_q     <= cfg_d;
            wcnt_q    <= wcnt_d;
            ptr_q     <= ptr_d;
            endless_q <= endless_d;
        end
    end

`ifdef RX_INTF_M_AXIS_UNDERRUN_CNT_EN
    logic [15:0] urun_q [NUM_CH];

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            for (int i = 0; i < NUM_CH; i++) urun_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_edge[i]) begin
                    urun_q[i] <= '0;
                end else if ((state_q == ST_SEND) && (ch_q == 2'(i)) && M_AXIS_TREADY &&
                             sel_empty && in_burst && (urun_q[i] != 16'hFFFF)) begin
                    urun_q[i] <= urun_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) underrun_cnt[i*16 +: 16] = urun_q[i];
    end
`endif

    assign pend_req      = pend_q;
    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = sel_data;
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = tlast;
    assign M_AXIS_TDEST  = TDEST_WIDTH'(ch_q);

endmodule

// File: tb/tb_rx_intf_m_axis_mc.sv
// ---------------------------------------------------------------------------
// tb_rx_intf_m_axis_mc
// Scoreboard bench: stimulus pushes hand-computed expected beats into exp_q,
// a monitor pops and compares on every M_AXIS handshake.
// ---------------------------------------------------------------------------
module tb_rx_intf_m_axis_mc;
    import rx_intf_m_axis_pkg::*;

    localparam int NUM_CH = 2;
    localparam int W      = 64;
    localparam int DEPTH  = 16;
    localparam int NB     = 14;
    localparam int WB     = 5;
    localparam int CW     = 5;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    logic                 clk;
    logic                 rst_n;
    logic                 endless_mode;
    logic [WB-1:0]        START_COUNT_CFG;
    logic [NUM_CH*NB-1:0] M_AXIS_NUM_DMA_SYMBOL;
    logic [NUM_CH-1:0]    start_1trans;
    logic [NUM_CH*W-1:0]  DATA_FROM_ACC;
    logic [NUM_CH-1:0]    ACC_DATA_READY;
    logic [NUM_CH-1:0]    FULLN_TO_ACC;
    logic [NUM_CH*CW-1:0] data_count;
    logic [NUM_CH-1:0]    pend_req;
`ifdef RX_INTF_M_AXIS_UNDERRUN_CNT_EN
    logic [NUM_CH*16-1:0] underrun_cnt;
`endif
    logic                 M_AXIS_TVALID;
    logic [W-1:0]         M_AXIS_TDATA;
    logic [W/8-1:0]       M_AXIS_TSTRB;
    logic                 M_AXIS_TLAST;
    logic [1:0]           M_AXIS_TDEST;
    logic                 M_AXIS_TREADY;

    int    checks = 0;
    int    errors = 0;
    bit    rand_ready = 0;
    beat_t exp_q[$];

    rx_intf_m_axis_mc #(
        .NUM_CH                 (NUM_CH),
        .C_M_AXIS_TDATA_WIDTH   (W),
        .FIFO_DEPTH             (DEPTH),
        .MAX_BIT_NUM_DMA_SYMBOL (NB),
        .WAIT_COUNT_BITS        (WB),
        .TDEST_WIDTH            (2)
    ) dut (
        .M_AXIS_ACLK           (clk),
        .M_AXIS_ARESETN        (rst_n),
        .endless_mode          (endless_mode),
        .START_COUNT_CFG       (START_COUNT_CFG),
        .M_AXIS_NUM_DMA_SYMBOL (M_AXIS_NUM_DMA_SYMBOL),
        .start_1trans          (start_1trans),
        .DATA_FROM_ACC         (DATA_FROM_ACC),
        .ACC_DATA_READY        (ACC_DATA_READY),
        .FULLN_TO_ACC          (FULLN_TO_ACC),
        .data_count            (data_count),
        .pend_req              (pend_req),
`ifdef RX_INTF_M_AXIS_UNDERRUN_CNT_EN
        .underrun_cnt          (underrun_cnt),
`endif
        .M_AXIS_TVALID         (M_AXIS_TVALID),
        .M_AXIS_TDATA          (M_AXIS_TDATA),
        .M_AXIS_TSTRB          (M_AXIS_TSTRB),
        .M_AXIS_TLAST          (M_AXIS_TLAST),
        .M_AXIS_TDEST          (M_AXIS_TDEST),
        .M_AXIS_TREADY         (M_AXIS_TREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int ch, input logic [63:0] d);
        DATA_FROM_ACC[ch*W +: W] = d;
        ACC_DATA_READY[ch]       = 1'b1;
        tick(1);
        ACC_DATA_READY[ch]       = 1'b0;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] mask);
        start_1trans = mask;
        tick(1);
        start_1trans = '0;
    endtask

    task automatic set_n(input int ch, input int n);
        M_AXIS_NUM_DMA_SYMBOL[ch*NB +: NB] = NB'(n);
    endtask

    task automatic expect_burst(input logic [63:0] base, input logic [1:0] dest,
                                input int n, input bit last_en);
        beat_t b;
        for (int k = 0; k <= n; k++) begin
            b.data = base + 64'(k);
            b.dest = dest;
            b.last = last_en && (k == n);
            exp_q.push_back(b);
        end
    endtask

    // Returns at the posedge on which the last expected beat transfers.
    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every handshake against the scoreboard, and check
    // that a stalled beat keeps its payload.
    initial begin
        beat_t       e;
        bit          stalled = 0;
        logic [63:0] held_data = '0;
        logic [1:0]  held_dest = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_tvalid", 64'(M_AXIS_TVALID), 64'd1);
                    check("stall_tdata", M_AXIS_TDATA, held_data);
                    check("stall_tdest", 64'(M_AXIS_TDEST), 64'(held_dest));
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tdata", M_AXIS_TDATA, e.data);
                        check("tdest", 64'(M_AXIS_TDEST), 64'(e.dest));
                        check("tlast", 64'(M_AXIS_TLAST), 64'(e.last));
                        check("tstrb", 64'(M_AXIS_TSTRB), 64'hFF);
                    end
                end
                stalled   = M_AXIS_TVALID && !M_AXIS_TREADY;
                held_data = M_AXIS_TDATA;
                held_dest = M_AXIS_TDEST;
            end
        end
    end

    // Random backpressure, driven late in the cycle so the main thread can
    // take TREADY back with a plain assignment.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) M_AXIS_TREADY = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst_n                 = 1'b0;
        endless_mode          = 1'b0;
        START_COUNT_CFG       = '0;
        M_AXIS_NUM_DMA_SYMBOL = '0;
        start_1trans          = '0;
        DATA_FROM_ACC         = '0;
        ACC_DATA_READY        = '0;
        M_AXIS_TREADY         = 1'b1;
        tick(3);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("rst_tdest", 64'(M_AXIS_TDEST), 64'd0);
        check("rst_pend", 64'(pend_req), 64'd0);
        check("rst_count", 64'(data_count), 64'd0);
        check("rst_fulln", 64'(FULLN_TO_ACC), 64'h3);
        rst_n = 1'b1;
        tick(2);

        // Basic: 8 words in ch0, N0=3 -> A00..A03, TLAST on the 4th.
        set_n(0, 3);
        for (int k = 0; k < 8; k++) write_word(0, 64'hA00 + 64'(k));
        expect_burst(64'hA00, 2'd0, 3, 1'b1);
        pulse_start(2'b01);
        check("pend_after_edge", 64'(pend_req), 64'h1);
        wait_drain("basic", 200);
        tick(3);
        check("basic_left_ch0", 64'(data_count[0 +: CW]), 64'd4);
        check("basic_pend", 64'(pend_req), 64'd0);

        // Round-robin: last grant was ch0, so ch1 goes first, then ch0.
        set_n(0, 1);
        set_n(1, 1);
        for (int k = 0; k < 4; k++) write_word(1, 64'hB00 + 64'(k));
        expect_burst(64'hB00, 2'd1, 1, 1'b1);
        expect_burst(64'hA04, 2'd0, 1, 1'b1);
        pulse_start(2'b11);
        wait_drain("rr1", 200);
        tick(3);
        expect_burst(64'hB02, 2'd1, 1, 1'b1);
        expect_burst(64'hA06, 2'd0, 1, 1'b1);
        pulse_start(2'b11);
        wait_drain("rr2", 200);
        tick(3);
        check("rr_count", 64'(data_count), 64'd0);
        check("rr_pend", 64'(pend_req), 64'd0);

        // Backpressure + underrun: N0=15, wait 3, one word every 3 cycles.
        START_COUNT_CFG = 5'd3;
        set_n(0, 15);
        expect_burst(64'hC00, 2'd0, 15, 1'b1);
        rand_ready = 1;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    write_word(0, 64'hC00 + 64'(k));
                    tick(2);
                end
            end
            begin
                pulse_start(2'b01);
                wait_drain("bp", 3000);
            end
        join
        rand_ready    = 0;
        M_AXIS_TREADY = 1'b1;
        tick(10);
        check("bp_count", 64'(data_count[0 +: CW]), 64'd0);
        check("bp_tvalid_idle", 64'(M_AXIS_TVALID), 64'd0);
`ifdef RX_INTF_M_AXIS_UNDERRUN_CNT_EN
        check("underrun_nonzero", 64'(underrun_cnt[0 +: 16] != 16'd0), 64'd1);
`endif

        // Full: 18 writes into a 16-deep ch1 FIFO, the last 2 are dropped.
        START_COUNT_CFG = 5'd0;
        for (int k = 0; k < 16; k++) write_word(1, 64'hD00 + 64'(k));
        check("full_fulln", 64'(FULLN_TO_ACC), 64'h1);
        check("full_count", 64'(data_count[CW +: CW]), 64'd16);
        write_word(1, 64'hD10);
        write_word(1, 64'hD11);
        check("full_count_drop", 64'(data_count[CW +: CW]), 64'd16);
        set_n(1, 15);
        expect_burst(64'hD00, 2'd1, 15, 1'b1);
        pulse_start(2'b10);
        wait_drain("full", 300);
        tick(3);
        check("full_fulln_after", 64'(FULLN_TO_ACC), 64'h3);
        check("full_count_after", 64'(data_count[CW +: CW]), 64'd0);

        // Endless: 100 beats on ch0, never TLAST, scheduler stays in SEND.
        endless_mode = 1'b1;
        set_n(0, 3);
        expect_burst(64'hE00, 2'd0, 99, 1'b0);
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    int guard = 0;
                    while (!FULLN_TO_ACC[0] && guard < 1000) begin
                        tick(1);
                        guard++;
                    end
                    write_word(0, 64'hE00 + 64'(k));
                end
            end
            begin
                pulse_start(2'b01);
                wait_drain("endless", 5000);
            end
        join
        tick(5);
        check("endless_state", 64'(dut.state_q), 64'(ST_SEND));
        // Clearing the mode mid-burst must not end the latched endless burst.
        endless_mode = 1'b0;
        expect_burst(64'hE64, 2'd0, 0, 1'b0);
        write_word(0, 64'hE64);
        wait_drain("endless_extra", 100);
        tick(5);
        check("endless_state_latched", 64'(dut.state_q), 64'(ST_SEND));

        // Leave endless via reset, then reset again in the middle of a burst.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        set_n(0, 7);
        for (int k = 0; k < 8; k++) write_word(0, 64'hF00 + 64'(k));
        expect_burst(64'hF00, 2'd0, 1, 1'b0);
        pulse_start(2'b01);
        wait_drain("pre_reset", 200);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("arst_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("arst_pend", 64'(pend_req), 64'd0);
        check("arst_count", 64'(data_count), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        set_n(0, 1);
        write_word(0, 64'h1A0);
        write_word(0, 64'h1A1);
        expect_burst(64'h1A0, 2'd0, 1, 1'b1);
        pulse_start(2'b01);
        wait_drain("post_reset", 200);
        tick(5);
        check("post_reset_count", 64'(data_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
